bcd_divider_seq: RTL and testbench

- Parametrised sequential restoring divider for the calculator datapath.
- Takes NDIG-digit BCD dividend/divisor from the keypad capture stage and converts them to binary.
- Computes one quotient bit per clock over the full binary width.
- Returns quotient/remainder through a valid/ready handshake with divide-by-zero and bad-digit flags; generalises the fixed 4-bit, start-pulse divider.

---
 rtl/bcd_div_pkg.sv | 36 +++
 rtl/bin2bcd_seq.sv | 65 ++++++
 rtl/bcd_divider_seq.sv | 148 ++++++++++++++
 tb/tb_bcd_divider_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_div_pkg.sv
// Shared types and BCD helpers for the sequential BCD divider.
// Digit decode treats 4'hF as a blank key (value 0) and 4'hA..4'hE as errors.
package bcd_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, CONV, DONE} state_t;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         BCD_MAXDIG = 4;

  function automatic logic bcd_digit_valid(input logic [3:0] nib);
    return (nib <= 4'd9) || (nib == BCD_BLANK);
  endfunction

  // Operands arrive zero-extended to BCD_MAXDIG digits; only the low ndig digits count.
  function automatic logic [13:0] bcd_to_bin(input logic [4*BCD_MAXDIG-1:0] bcd, input int ndig);
    logic [13:0] acc;
    logic [3:0]  nib;
    acc = '0;
    for (int i = BCD_MAXDIG - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (i < ndig)
        acc = acc * 14'd10 + ((nib <= 4'd9) ? {10'd0, nib} : 14'd0);
    end
    return acc;
  endfunction

  function automatic logic bcd_any_err(input logic [4*BCD_MAXDIG-1:0] bcd, input int ndig);
    logic err;
    err = 1'b0;
    for (int i = 0; i < BCD_MAXDIG; i++)
      if (i < ndig && !bcd_digit_valid(bcd[4*i +: 4]))
        err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter for two W-bit values in parallel; W cycles after i_start.
// o_done is high during the final shift cycle; results hold until the next i_start.
module bin2bcd_seq
  import bcd_div_pkg::*;
#(
  parameter int W    = 7,
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [W-1:0]      i_bin_a,
  input  logic [W-1:0]      i_bin_b,
  output logic [4*NDIG-1:0] o_bcd_a,
  output logic [4*NDIG-1:0] o_bcd_b,
  output logic              o_done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]      r_sh_a, r_sh_b;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic [4*NDIG-1:0] w_adj_a, w_adj_b;

  function automatic logic [4*NDIG-1:0] add3(input logic [4*NDIG-1:0] v);
    logic [4*NDIG-1:0] o;
    o = v;
    for (int i = 0; i < NDIG; i++)
      if (v[4*i +: 4] >= 4'd5)
        o[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return o;
  endfunction

  assign w_adj_a = add3(o_bcd_a);
  assign w_adj_b = add3(o_bcd_b);
  assign o_done  = r_busy && (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      o_bcd_a <= '0;
      o_bcd_b <= '0;
    end else if (i_start) begin
      r_sh_a  <= i_bin_a;
      r_sh_b  <= i_bin_b;
      r_cnt   <= CW'(W);
      r_busy  <= 1'b1;
      o_bcd_a <= '0;
      o_bcd_b <= '0;
    end else if (r_busy) begin
      o_bcd_a <= (w_adj_a << 1) | (4*NDIG)'(r_sh_a[W-1]);
      o_bcd_b <= (w_adj_b << 1) | (4*NDIG)'(r_sh_b[W-1]);
      r_sh_a  <= r_sh_a << 1;
      r_sh_b  <= r_sh_b << 1;
      r_cnt   <= r_cnt - CW'(1);
      if (r_cnt == CW'(1))
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_divider_seq.sv
// Restoring BCD-operand divider: W+1 edges accept-to-result (2W+1 with BCD_DIV_BCD_OUT_EN), 1 edge on error.
// Result held in DONE until out_ready; in_ready low from accept until the result is taken.
module bcd_divider_seq
  import bcd_div_pkg::*;
#(
  parameter  int NDIG = 2,
  localparam int W    = $clog2(10**NDIG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a_bcd,
  input  logic [4*NDIG-1:0] b_bcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      quotient,
  output logic [W-1:0]      remainder,
  output logic              div_by_zero,
  output logic              bcd_err
`ifdef BCD_DIV_BCD_OUT_EN
  ,
  output logic [4*NDIG-1:0] quotient_bcd,
  output logic [4*NDIG-1:0] remainder_bcd
`endif
);

  localparam int IW = $clog2(W);

  state_t        r_state;
  logic [W-1:0]  r_a, r_b;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  w_a_bin, w_b_bin;
  logic          w_err;
  logic [W:0]    w_rs, w_d;
  logic [W-1:0]  w_r_next;

  assign w_a_bin  = W'(bcd_to_bin(16'(a_bcd), NDIG));
  assign w_b_bin  = W'(bcd_to_bin(16'(b_bcd), NDIG));
  assign w_err    = bcd_any_err(16'(a_bcd), NDIG) || bcd_any_err(16'(b_bcd), NDIG);
  // Top bit of the W+1-bit difference is the borrow: set means the trial subtract failed.
  assign w_rs     = {remainder, r_a[r_idx]};
  assign w_d      = w_rs - {1'b0, r_b};
  assign w_r_next = w_d[W] ? w_rs[W-1:0] : w_d[W-1:0];

`ifdef BCD_DIV_BCD_OUT_EN
  logic              r_blank;
  logic              w_cv_start, w_cv_done;
  logic [4*NDIG-1:0] w_q_bcd, w_r_bcd;

  assign w_cv_start = (r_state == RUN) && (r_idx == '0);

  bin2bcd_seq #(.W(W), .NDIG(NDIG)) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_cv_start),
    .i_bin_a ({quotient[W-1:1], ~w_d[W]}),
    .i_bin_b (w_r_next),
    .o_bcd_a (w_q_bcd),
    .o_bcd_b (w_r_bcd),
    .o_done  (w_cv_done)
  );

  assign quotient_bcd  = r_blank ? {NDIG{BCD_BLANK}} : w_q_bcd;
  assign remainder_bcd = r_blank ? {NDIG{BCD_BLANK}} : w_r_bcd;

  always_ff @(posedge clk) begin
    if (rst)
      r_blank <= 1'b0;
    else if (in_valid && in_ready)
      r_blank <= w_err || (w_b_bin == '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      bcd_err     <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a         <= w_a_bin;
            r_b         <= w_b_bin;
            r_idx       <= IW'(W - 1);
            in_ready    <= 1'b0;
            bcd_err     <= w_err;
            div_by_zero <= !w_err && (w_b_bin == '0);
            if (w_err) begin
              quotient  <= '0;
              remainder <= '0;
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else if (w_b_bin == '0) begin
              quotient  <= '1;
              remainder <= w_a_bin;
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else begin
              quotient  <= '0;
              remainder <= '0;
              r_state   <= RUN;
            end
          end
        end
        RUN: begin
          remainder       <= w_r_next;
          quotient[r_idx] <= ~w_d[W];
          if (r_idx == '0) begin
`ifdef BCD_DIV_BCD_OUT_EN
            r_state   <= CONV;
`else
            r_state   <= DONE;
            out_valid <= 1'b1;
`endif
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
`ifdef BCD_DIV_BCD_OUT_EN
        CONV: begin
          if (w_cv_done) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_divider_seq.sv
// Directed bench for bcd_divider_seq at NDIG=2 and NDIG=3; honours BCD_DIV_BCD_OUT_EN.
// Outputs are sampled 1 time unit after the rising edge; inputs change on the falling edge.
module tb_bcd_divider_seq;

  localparam int W2 = 7;
  localparam int W3 = 10;
`ifdef BCD_DIV_BCD_OUT_EN
  localparam int LAT2 = 2*W2 + 1;
  localparam int LAT3 = 2*W3 + 1;
`else
  localparam int LAT2 = W2 + 1;
  localparam int LAT3 = W3 + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          iv2 = 1'b0, or2 = 1'b0, ir2, ov2, dz2, er2;
  logic [7:0]    a2 = '0, b2 = '0;
  logic [W2-1:0] q2, r2;
  logic          iv3 = 1'b0, or3 = 1'b0, ir3, ov3, dz3, er3;
  logic [11:0]   a3 = '0, b3 = '0;
  logic [W3-1:0] q3, r3;
`ifdef BCD_DIV_BCD_OUT_EN
  logic [7:0]    qb2, rb2;
  logic [11:0]   qb3, rb3;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  bcd_divider_seq #(.NDIG(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_bcd(a2), .b_bcd(b2),
    .out_valid(ov2), .out_ready(or2), .quotient(q2), .remainder(r2),
    .div_by_zero(dz2), .bcd_err(er2)
`ifdef BCD_DIV_BCD_OUT_EN
    , .quotient_bcd(qb2), .remainder_bcd(rb2)
`endif
  );

  bcd_divider_seq #(.NDIG(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a_bcd(a3), .b_bcd(b3),
    .out_valid(ov3), .out_ready(or3), .quotient(q3), .remainder(r3),
    .div_by_zero(dz3), .bcd_err(er3)
`ifdef BCD_DIV_BCD_OUT_EN
    , .quotient_bcd(qb3), .remainder_bcd(rb3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present operands, count edges from the accept edge (=1) until out_valid shows.
  task automatic run2(input logic [7:0] a, input logic [7:0] b, output int l);
    @(negedge clk);
    chk("ready_before_accept2", ir2, 1);
    a2 = a; b2 = b; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    l = 1;
    while (!ov2 && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic take2;
    @(negedge clk); or2 = 1'b1;
    @(posedge clk); #1; or2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", ir2, 1);
    chk("rst_out_valid", ov2, 0);
    chk("rst_quotient", q2, 0);
    chk("rst_remainder", r2, 0);
    chk("rst_flags", {dz2, er2}, 0);
    @(negedge clk); rst = 1'b0;

    // 99/7
    run2(8'h99, 8'h07, lat);
    chk("99_7_latency", lat, LAT2);
    chk("99_7_q", q2, 14);
    chk("99_7_r", r2, 1);
    chk("99_7_flags", {dz2, er2}, 0);
`ifdef BCD_DIV_BCD_OUT_EN
    chk("99_7_qbcd", qb2, 8'h14);
    chk("99_7_rbcd", rb2, 8'h01);
`endif
    take2();
    chk("after_take_valid", ov2, 0);
    chk("after_take_ready", ir2, 1);

    // blank tens digits: 5/2
    run2(8'hF5, 8'hF2, lat);
    chk("blank_latency", lat, LAT2);
    chk("blank_q", q2, 2);
    chk("blank_r", r2, 1);
    take2();

    // divide by zero
    run2(8'h12, 8'h00, lat);
    chk("dz_latency", lat, 1);
    chk("dz_flag", dz2, 1);
    chk("dz_err", er2, 0);
    chk("dz_q", q2, 7'h7F);
    chk("dz_r", r2, 12);
`ifdef BCD_DIV_BCD_OUT_EN
    chk("dz_qbcd", qb2, 8'hFF);
    chk("dz_rbcd", rb2, 8'hFF);
`endif
    take2();

    // bad digit
    run2(8'h1A, 8'h03, lat);
    chk("err_latency", lat, 1);
    chk("err_flag", er2, 1);
    chk("err_dz", dz2, 0);
    chk("err_q", q2, 0);
    chk("err_r", r2, 0);
    take2();

    // back-pressure with a competing in_valid during the hold
    run2(8'h50, 8'h06, lat);
    chk("bp_latency", lat, LAT2);
    a2 = 8'h11; b2 = 8'h01; iv2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", ov2, 1);
      chk("bp_q", q2, 8);
      chk("bp_r", r2, 2);
      chk("bp_ready", ir2, 0);
    end
    iv2 = 1'b0;
    take2();
    chk("bp_released_valid", ov2, 0);
    chk("bp_held_q", q2, 8);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_accept_valid", ov2, 0);
    chk("bp_no_accept_ready", ir2, 1);

    // reset in the third RUN cycle
    @(negedge clk);
    a2 = 8'h99; b2 = 8'h07; iv2 = 1'b1;
    @(posedge clk); #1; iv2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", ir2, 1);
    chk("midrst_valid", ov2, 0);
    chk("midrst_q", q2, 0);
    chk("midrst_r", r2, 0);
    chk("midrst_flags", {dz2, er2}, 0);
    run2(8'h64, 8'h08, lat);
    chk("64_8_latency", lat, LAT2);
    chk("64_8_q", q2, 8);
    chk("64_8_r", r2, 0);
    take2();

    // NDIG=3: 999/10
    @(negedge clk);
    chk("n3_ready", ir3, 1);
    a3 = 12'h999; b3 = 12'h010; iv3 = 1'b1;
    @(posedge clk); #1; iv3 = 1'b0;
    lat = 1;
    while (!ov3 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n3_latency", lat, LAT3);
    chk("n3_q", q3, 99);
    chk("n3_r", r3, 9);
    chk("n3_flags", {dz3, er3}, 0);
`ifdef BCD_DIV_BCD_OUT_EN
    chk("n3_qbcd", qb3, 12'h099);
    chk("n3_rbcd", rb3, 12'h009);
`endif
    @(negedge clk); or3 = 1'b1;
    @(posedge clk); #1; or3 = 1'b0;
    chk("n3_taken", ov3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
